servo_motion_ctrl: RTL and testbench

- Command sequencer for one hobby-servo PWM channel.
- Accepts angle commands (0–180°) on a valid/ready handshake and maps each to a pulse-width tick count.
- Slews the commanded width toward the target by a bounded step once per 20 ms PWM frame, holds for a settle period, then reports completion.
- Owns the frame timebase and drives pulse width plus PWM output. Sits between top-level command logic (switches/FSM) and the servo pin.

---
 rtl/servo_pkg.sv | 17 +
 rtl/servo_frame_timer.sv | 35 +++
 rtl/servo_motion_ctrl.sv | 113 +++++++++++
 tb/tb_servo_motion_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared types and default constants for the servo motion controller.
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAP    = 2'd1,
    MOVING = 2'd2,
    SETTLE = 2'd3
  } state_t;

  localparam int FRAME_TICKS   = 1000000;  // 20 ms at 50 MHz
  localparam int POS_0         = 50000;    // 1.0 ms pulse = 0 degrees
  localparam int TICKS_PER_DEG = 278;
  localparam int DEG_MAX       = 180;
  localparam int POS_CENTER    = POS_0 + (DEG_MAX / 2) * TICKS_PER_DEG;

endpackage

// File: rtl/servo_frame_timer.sv
// PWM frame timebase: free-running frame counter, boundary/start flags and a
// registered PWM level compared against the width that applies next cycle.
module servo_frame_timer #(
  parameter int FRAME_TICKS = 1000000,
  parameter int W           = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] width,
  output logic         boundary,
  output logic         frame_start,
  output logic         servo
);

  logic [W-1:0] frame_cnt;
  logic [W-1:0] cnt_next;

  assign boundary    = (frame_cnt == W'(FRAME_TICKS - 1));
  assign frame_start = (frame_cnt == '0);
  assign cnt_next    = boundary ? '0 : frame_cnt + 1'b1;

  // Frame counter and glitch-free PWM level aligned with the counter.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values and simulation matches the synthesized registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      servo     <= 1'b0;
    end else begin
      frame_cnt <= cnt_next;
      servo     <= (cnt_next < width);
    end
  end

endmodule

// File: rtl/servo_motion_ctrl.sv
// Command sequencer for one hobby-servo channel: accepts an angle, maps it to
// a pulse width, slews toward it once per frame, settles, then pulses done.
module servo_motion_ctrl #(
  parameter int FRAME_TICKS   = servo_pkg::FRAME_TICKS,
  parameter int POS_0         = servo_pkg::POS_0,
  parameter int TICKS_PER_DEG = servo_pkg::TICKS_PER_DEG,
  parameter int SLEW          = 2780,
  parameter int SETTLE_FRAMES = 10,
  parameter int W             = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  input  logic [7:0]   cmd_deg,
  output logic         cmd_ready,
  output logic         busy,
  output logic         done,
  output logic         frame_start,
  output logic [W-1:0] pulse_width,
  output logic         servo
);

  import servo_pkg::*;

  localparam int POS_CTR = POS_0 + (DEG_MAX / 2) * TICKS_PER_DEG;
  localparam int SC_W    = $clog2(SETTLE_FRAMES + 1);
  localparam logic signed [W:0] SLEW_S = (W + 1)'(SLEW);

  state_t            state, state_next;
  logic [7:0]        deg_lat;
  logic [7:0]        deg_clamped;
  logic [W-1:0]      target;
  logic [W-1:0]      width_next;
  logic [SC_W-1:0]   settle_cnt;
  logic signed [W:0] diff;
  logic              boundary;
  logic              in_reach;
  logic              settle_last;

  assign deg_clamped = (cmd_deg > 8'(DEG_MAX)) ? 8'(DEG_MAX) : cmd_deg;
  assign diff        = $signed({1'b0, target}) - $signed({1'b0, pulse_width});
  assign in_reach    = (diff <= SLEW_S) && (diff >= -SLEW_S);
  assign settle_last = (settle_cnt == SC_W'(SETTLE_FRAMES - 1));

  // Width applied from the next edge on; only moves on a frame boundary.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    width_next = pulse_width;
    if (state == MOVING && boundary) begin
      if (in_reach)     width_next = target;
      else if (diff[W]) width_next = pulse_width - W'(SLEW);
      else              width_next = pulse_width + W'(SLEW);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid)                 state_next = MAP;
      MAP:                                    state_next = MOVING;
      MOVING:  if (boundary && in_reach)      state_next = SETTLE;
      SETTLE:  if (boundary && settle_last)   state_next = IDLE;
      default:                                state_next = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

  // Datapath: latched angle, target, applied width, settle count, done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      deg_lat     <= '0;
      target      <= W'(POS_CTR);
      pulse_width <= W'(POS_CTR);
      settle_cnt  <= '0;
      done        <= 1'b0;
    end else begin
      pulse_width <= width_next;
      done        <= (state == SETTLE) && boundary && settle_last;
      case (state)
        IDLE:    if (cmd_valid) deg_lat <= deg_clamped;
        MAP:     target <= W'(POS_0) + W'(deg_lat) * W'(TICKS_PER_DEG);
        MOVING:  if (boundary && in_reach) settle_cnt <= '0;
        SETTLE:  if (boundary) settle_cnt <= settle_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  servo_frame_timer #(
    .FRAME_TICKS (FRAME_TICKS),
    .W           (W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .width       (width_next),
    .boundary    (boundary),
    .frame_start (frame_start),
    .servo       (servo)
  );

endmodule

// File: tb/tb_servo_motion_ctrl.sv
// Directed bench for servo_motion_ctrl with a shrunken timebase.
module tb_servo_motion_ctrl;

  localparam int FT     = 1000;
  localparam int POS0   = 100;
  localparam int TPD    = 2;
  localparam int SLEW   = 50;
  localparam int SETTLE = 2;
  localparam int W      = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic [7:0]   cmd_deg;
  logic         cmd_ready;
  logic         busy;
  logic         done;
  logic         frame_start;
  logic [W-1:0] pulse_width;
  logic         servo;

  int total = 0;
  int bad   = 0;
  int mw;        // expected applied width
  int w_start;   // width in force since the last frame start
  bit aligned;   // currently sampling at a frame-start cycle

  servo_motion_ctrl #(
    .FRAME_TICKS   (FT),
    .POS_0         (POS0),
    .TICKS_PER_DEG (TPD),
    .SLEW          (SLEW),
    .SETTLE_FRAMES (SETTLE),
    .W             (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_deg     (cmd_deg),
    .cmd_ready   (cmd_ready),
    .busy        (busy),
    .done        (done),
    .frame_start (frame_start),
    .pulse_width (pulse_width),
    .servo       (servo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next frame start, counting servo-high samples on the way.
  task automatic next_frame(output int hi, output int n);
    hi = 0;
    n  = 0;
    do begin
      if (servo) hi++;
      @(negedge clk);
      n++;
    end while (!frame_start && n < 2 * FT);
    if (!frame_start) check("frame_timeout", n, FT);
  endtask

  task automatic issue(input int deg);
    cmd_deg   = 8'(deg);
    cmd_valid = 1'b1;
    @(negedge clk);
    check("accept_busy", busy, 1);
    check("accept_rdy", cmd_ready, 0);
    aligned = 1'b0;
  endtask

  // Follow a motion to completion, predicting width and done per boundary.
  task automatic follow(input int tgt);
    int hi, n, d, sc, guard;
    bit moving, exp_done;
    moving   = 1'b1;
    exp_done = 1'b0;
    sc       = 0;
    guard    = 0;
    while (!exp_done && guard < 40) begin
      guard++;
      next_frame(hi, n);
      if (aligned) begin
        check("servo_hi", hi, w_start);
        check("frame_len", n, FT);
      end
      aligned = 1'b1;
      if (moving) begin
        d = tgt - mw;
        if (d <= SLEW && d >= -SLEW) begin
          mw     = tgt;
          moving = 1'b0;
        end else begin
          mw += (d > 0) ? SLEW : -SLEW;
        end
      end else begin
        sc++;
        exp_done = (sc == SETTLE);
      end
      check("width", pulse_width, mw);
      check("done", done, exp_done);
      check("busy", busy, !exp_done);
      check("ready", cmd_ready, exp_done);
      w_start = mw;
    end
    @(negedge clk);
    check("done_pulse_len", done, 0);
    aligned = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi, n, dcount;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_deg   = '0;
    mw        = 280;
    w_start   = 280;
    aligned   = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_width", pulse_width, 280);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_servo", servo, 0);
    check("rst_fstart", frame_start, 1);
    rst = 1'b0;

    // Idle PWM: 280 high cycles per 1000-cycle frame.
    next_frame(hi, n);
    next_frame(hi, n);
    check("idle_servo_hi", hi, 280);
    check("idle_frame_len", n, FT);
    aligned = 1'b1;

    // Full swing to 180 degrees: 330, 380, 430, 460.
    issue(180);
    cmd_valid = 1'b0;
    follow(460);

    // Out-of-range angle clamps to 180, then down to 0 with a floor at 100.
    issue(200);
    cmd_valid = 1'b0;
    follow(460);
    issue(0);
    cmd_valid = 1'b0;
    follow(100);

    // Back to centre, then re-command centre with cmd_valid held throughout.
    issue(90);
    cmd_valid = 1'b0;
    follow(280);
    issue(90);
    follow(280);
    check("reaccept_on_done", busy, 1);
    cmd_valid = 1'b0;
    follow(280);

    // Reset in the middle of a move at width 380.
    issue(180);
    cmd_valid = 1'b0;
    next_frame(hi, n);
    check("pre_rst_w1", pulse_width, 330);
    next_frame(hi, n);
    check("pre_rst_w2", pulse_width, 380);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_width", pulse_width, 280);
    check("midrst_fstart", frame_start, 1);
    check("midrst_ready", cmd_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_servo", servo, 0);
    rst    = 1'b0;
    mw     = 280;
    dcount = 0;
    for (int i = 0; i < 3 * FT; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("midrst_no_done", dcount, 0);
    check("midrst_width_hold", pulse_width, 280);

    // Command offered on the boundary cycle: that boundary is not used.
    next_frame(hi, n);
    repeat (FT - 1) @(negedge clk);
    check("bnd_pre_fstart", frame_start, 0);
    cmd_deg   = 8'd120;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bnd_fstart", frame_start, 1);
    check("bnd_width", pulse_width, 280);
    check("bnd_busy", busy, 1);
    aligned = 1'b1;
    w_start = 280;
    follow(340);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
